// File: rtl/sio_fifo_bridge.sv
// Buffered CPU front end for the byte-wide serial I/O block: a TX FIFO, an RX FIFO
// and a sequencer that polls the serial block status and moves bytes in both directions.

module sio_fifo_bridge #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ce,
    input  logic       rd,
    input  logic       wr,
    input  logic       cd,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       rx_irq,
    output logic       sio_ce,
    output logic       sio_rd,
    output logic       sio_wr,
    output logic       sio_cd,
    output logic [7:0] sio_data_in,
    input  logic [7:0] sio_data_out
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned CntW  = DEPTH_LOG2 + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    localparam logic [2:0] StPollIssue = 3'd0;
    localparam logic [2:0] StPollWait  = 3'd1;
    localparam logic [2:0] StRxIssue   = 3'd2;
    localparam logic [2:0] StRxWait    = 3'd3;
    localparam logic [2:0] StTxWrite   = 3'd4;

    // CPU access decode
    logic acc;
    logic acc_q;
    logic acc_start;
    logic cpu_rd;
    logic cpu_wr;
    logic flush;

    assign acc       = ce && (rd || wr);
    assign acc_start = acc && !acc_q;
    assign cpu_rd    = acc_start && rd;
    assign cpu_wr    = acc_start && !rd;
    assign flush     = cpu_wr && cd && data_in[0];

    // Sequencer state
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       rx_rdy_q;
    logic       tx_rdy_q;
    logic       rd_issued_q;
    logic       poll_rx;
    logic       poll_tx;

    // TX FIFO
    logic [7:0]            tx_mem [Depth];
    logic [DEPTH_LOG2-1:0] tx_wptr_q;
    logic [DEPTH_LOG2-1:0] tx_rptr_q;
    logic [CntW-1:0]       tx_cnt_q;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_push;
    logic                  tx_pop;

    // RX FIFO
    logic [7:0]            rx_mem [Depth];
    logic [DEPTH_LOG2-1:0] rx_wptr_q;
    logic [DEPTH_LOG2-1:0] rx_rptr_q;
    logic [CntW-1:0]       rx_cnt_q;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_push;
    logic                  rx_pop;

    logic       tx_idle;
    logic [7:0] status;

    assign tx_full  = (tx_cnt_q == CntFull);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CntFull);
    assign rx_empty = (rx_cnt_q == '0);

    assign tx_push = cpu_wr && !cd && !tx_full;
    assign tx_pop  = (state_q == StTxWrite) && !tx_empty;
    assign rx_push = (state_q == StRxWait) && rd_issued_q && !rx_full;
    assign rx_pop  = cpu_rd && !cd && !rx_empty;

    assign tx_idle = tx_empty && tx_rdy_q && (state_q != StTxWrite);
    assign status  = {5'b0, tx_idle, !rx_empty, !tx_full};

    // The first poll after reset goes out with its strobes still held low, so the
    // bus is only trusted when a read strobe really was driven the cycle before.
    assign poll_rx = rd_issued_q ? sio_data_out[1] : rx_rdy_q;
    assign poll_tx = rd_issued_q ? sio_data_out[0] : tx_rdy_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc;
        end
    end

    // TX FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr_q <= tx_wptr_q + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr_q <= tx_rptr_q + 1'b1;
            end
            tx_cnt_q <= tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
        end
    end

    // RX FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr_q] <= sio_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr_q <= rx_wptr_q + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr_q <= rx_rptr_q + 1'b1;
            end
            rx_cnt_q <= rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
        end
    end

    // Sequencer next state
    always_comb begin
        state_d = StPollIssue;
        case (state_q)
            StPollIssue: state_d = StPollWait;
            StPollWait: begin
                if (poll_rx && !rx_full) begin
                    state_d = StRxIssue;
                end else if (poll_tx && !tx_empty) begin
                    state_d = StTxWrite;
                end else begin
                    state_d = StPollIssue;
                end
            end
            StRxIssue: state_d = StRxWait;
            StRxWait: begin
                if (tx_rdy_q && !tx_empty) begin
                    state_d = StTxWrite;
                end else begin
                    state_d = StPollIssue;
                end
            end
            StTxWrite: state_d = StPollIssue;
            default:   state_d = StPollIssue;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= StPollIssue;
            rx_rdy_q    <= 1'b0;
            tx_rdy_q    <= 1'b1;
            rd_issued_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_issued_q <= sio_rd;
            if (state_q == StPollWait && rd_issued_q) begin
                rx_rdy_q <= sio_data_out[1];
                tx_rdy_q <= sio_data_out[0];
            end
        end
    end

    // Serial strobes are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sio_ce      <= 1'b0;
            sio_rd      <= 1'b0;
            sio_wr      <= 1'b0;
            sio_cd      <= 1'b0;
            sio_data_in <= 8'h00;
        end else begin
            sio_ce      <= (state_d == StPollIssue) || (state_d == StRxIssue) ||
                           (state_d == StTxWrite);
            sio_rd      <= (state_d == StPollIssue) || (state_d == StRxIssue);
            sio_wr      <= (state_d == StTxWrite);
            sio_cd      <= (state_d == StPollIssue);
            sio_data_in <= (state_d == StTxWrite) ? tx_mem[tx_rptr_q] : 8'h00;
        end
    end

    // CPU read data and RX interrupt
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            data_out <= 8'h00;
            rx_irq   <= 1'b0;
        end else begin
            rx_irq <= !rx_empty;
            if (cpu_rd) begin
                if (cd) begin
                    data_out <= status;
                end else begin
                    data_out <= rx_empty ? 8'h00 : rx_mem[rx_rptr_q];
                end
            end else if (!acc) begin
                data_out <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_sio_fifo_bridge.sv
// Directed bench for sio_fifo_bridge with a small behavioural model of the serial block.

module tb_sio_fifo_bridge;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       ce;
    logic       rd;
    logic       wr;
    logic       cd;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rx_irq;
    logic       sio_ce;
    logic       sio_rd;
    logic       sio_wr;
    logic       sio_cd;
    logic [7:0] sio_data_in;
    logic [7:0] sio_data_out;

    int n_checks = 0;
    int n_pass   = 0;

    sio_fifo_bridge #(
        .DEPTH_LOG2(4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .ce          (ce),
        .rd          (rd),
        .wr          (wr),
        .cd          (cd),
        .data_in     (data_in),
        .data_out    (data_out),
        .rx_irq      (rx_irq),
        .sio_ce      (sio_ce),
        .sio_rd      (sio_rd),
        .sio_wr      (sio_wr),
        .sio_cd      (sio_cd),
        .sio_data_in (sio_data_in),
        .sio_data_out(sio_data_out)
    );

    always #5 clk = ~clk;

    // Serial block model: registered read data one cycle after the strobe.
    logic [7:0] ser_rx[$];
    logic [7:0] ser_tx[$];
    logic       ser_tx_ready = 1'b1;
    int         ser_data_reads = 0;
    logic       bus_en = 1'b0;
    logic [7:0] bus_val = 8'h00;

    // Idle bus reads as all-ones (pulled up).
    assign sio_data_out = bus_en ? bus_val : 8'hFF;

    always @(posedge clk) begin
        bus_en <= 1'b0;
        if (sio_ce && sio_rd) begin
            bus_en <= 1'b1;
            if (sio_cd) begin
                bus_val <= {6'b0, ser_rx.size() != 0, ser_tx_ready};
            end else begin
                ser_data_reads <= ser_data_reads + 1;
                if (ser_rx.size() != 0) bus_val <= ser_rx.pop_front();
                else bus_val <= 8'hEE;
            end
        end
        if (sio_ce && sio_wr) ser_tx.push_back(sio_data_in);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic cpu_read(input logic c, output logic [7:0] v);
        @(negedge clk);
        ce = 1'b1; rd = 1'b1; wr = 1'b0; cd = c;
        @(negedge clk);
        v = data_out;
        ce = 1'b0; rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic c, input logic [7:0] d);
        @(negedge clk);
        ce = 1'b1; wr = 1'b1; rd = 1'b0; cd = c; data_in = d;
        @(negedge clk);
        ce = 1'b0; wr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        logic [3:0] prev;
        logic [3:0] cur;
        int issues;
        int bad;
        int n;
        int tx_base;

        ce = 1'b0; rd = 1'b0; wr = 1'b0; cd = 1'b0; data_in = 8'h00;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_rx_irq", rx_irq, 1'b0);
        check("rst_strobes", {sio_ce, sio_rd, sio_wr, sio_cd}, 4'b0000);
        check("rst_sio_data", sio_data_in, 8'h00);
        n_rst = 1'b1;

        // Idle poll loop: status read strobe every other cycle
        repeat (2) @(negedge clk);
        prev = {sio_ce, sio_rd, sio_wr, sio_cd};
        issues = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cur = {sio_ce, sio_rd, sio_wr, sio_cd};
            if (cur == 4'b1101) issues++;
            else if (cur != 4'b0000) bad++;
            if (cur == prev) bad++;
            prev = cur;
        end
        check("poll_issues", issues, 8'd4);
        check("poll_pattern", bad, 8'd0);

        cpu_read(1'b1, v);
        check("status_reset", v, 8'h05);
        check("dout_idle", data_out, 8'h00);

        // RX path
        ser_rx.push_back(8'hA5);
        for (n = 0; n < 40 && !rx_irq; n++) @(negedge clk);
        check("rx_irq_rise", rx_irq, 1'b1);
        check("rx_sio_reads", ser_data_reads, 8'd1);
        cpu_read(1'b1, v);
        check("status_rx", v, 8'h07);
        @(negedge clk);
        ce = 1'b1; rd = 1'b1; cd = 1'b0;
        @(negedge clk);
        check("rx_data_a5", data_out, 8'hA5);
        check("irq_at_pop", rx_irq, 1'b1);
        ce = 1'b0; rd = 1'b0;
        @(negedge clk);
        check("irq_fall", rx_irq, 1'b0);
        check("dout_after_rd", data_out, 8'h00);

        // TX path
        tx_base = ser_tx.size();
        cpu_write(1'b0, 8'h3C);
        cpu_write(1'b0, 8'h7E);
        for (n = 0; n < 60 && (ser_tx.size() - tx_base) < 2; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("tx_count2", ser_tx.size() - tx_base, 8'd2);
        if (ser_tx.size() - tx_base >= 2) begin
            check("tx_byte0", ser_tx[tx_base], 8'h3C);
            check("tx_byte1", ser_tx[tx_base+1], 8'h7E);
        end
        cpu_read(1'b1, v);
        check("status_tx_done", v, 8'h05);

        // TX FIFO fill with transmitter busy
        ser_tx_ready = 1'b0;
        repeat (8) @(negedge clk);
        tx_base = ser_tx.size();
        for (int i = 0; i < 17; i++) begin
            cpu_write(1'b0, 8'(8'h40 + i));
            if (i == 14) begin
                cpu_read(1'b1, v);
                check("status_15", v, 8'h01);
            end
            if (i == 15) begin
                cpu_read(1'b1, v);
                check("status_16", v, 8'h00);
            end
        end
        cpu_read(1'b1, v);
        check("status_17", v, 8'h00);
        check("tx_held", ser_tx.size() - tx_base, 8'd0);
        ser_tx_ready = 1'b1;
        for (n = 0; n < 300 && (ser_tx.size() - tx_base) < 16; n++) @(negedge clk);
        repeat (30) @(negedge clk);
        check("tx_count16", ser_tx.size() - tx_base, 8'd16);
        for (int i = 0; i < 16; i++) begin
            if (tx_base + i < ser_tx.size()) check("tx_order", ser_tx[tx_base+i], 8'(8'h40 + i));
        end

        // Held data read: one pop only
        ser_rx.push_back(8'h11);
        ser_rx.push_back(8'h22);
        for (n = 0; n < 60 && ser_rx.size() != 0; n++) @(negedge clk);
        repeat (6) @(negedge clk);
        ce = 1'b1; rd = 1'b1; cd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_rd", data_out, 8'h11);
        end
        ce = 1'b0; rd = 1'b0;
        @(negedge clk);
        check("held_rd_end", data_out, 8'h00);
        cpu_read(1'b0, v);
        check("rx_second", v, 8'h22);
        cpu_read(1'b0, v);
        check("rx_empty_rd", v, 8'h00);
        check("rx_irq_empty", rx_irq, 1'b0);

        // Flush in the same cycle RX_WAIT captures a byte
        ser_tx_ready = 1'b0;
        repeat (8) @(negedge clk);
        cpu_write(1'b0, 8'h99);
        cpu_write(1'b0, 8'h98);
        tx_base = ser_tx.size();
        ser_rx.push_back(8'h55);
        for (n = 0; n < 40 && !(sio_ce && sio_rd && !sio_cd); n++) @(negedge clk);
        check("rx_issue_seen", sio_ce && sio_rd && !sio_cd, 1'b1);
        @(negedge clk);
        ce = 1'b1; wr = 1'b1; rd = 1'b0; cd = 1'b1; data_in = 8'h01;
        @(negedge clk);
        ce = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("flush_irq", rx_irq, 1'b0);
        cpu_read(1'b1, v);
        check("flush_status", v, 8'h01);
        cpu_read(1'b0, v);
        check("flush_rd", v, 8'h00);
        ser_tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("flush_tx_none", ser_tx.size() - tx_base, 8'd0);

        // Reset with a byte sitting in the RX FIFO
        ser_rx.push_back(8'h77);
        for (n = 0; n < 40 && !rx_irq; n++) @(negedge clk);
        check("pre_rst_irq", rx_irq, 1'b1);
        n_rst = 1'b0;
        @(negedge clk);
        check("mid_rst_irq", rx_irq, 1'b0);
        check("mid_rst_strobes", {sio_ce, sio_rd, sio_wr, sio_cd}, 4'b0000);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        cpu_read(1'b0, v);
        check("post_rst_rd", v, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sio_fifo_bridge.md
# sio_fifo_bridge

Buffered front end for the byte-wide serial I/O block. It sits between the Z80 bus decode and the serial I/O block. It presents the CPU with the same command/data register pair, backed by a TX FIFO and an RX FIFO. An internal sequencer continuously polls the serial block's status register, drains received bytes into the RX FIFO and feeds queued bytes to the transmitter, so the CPU no longer has to service every character at baud rate.

## Interface
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries each); occupancy counters are DEPTH_LOG2+1 bits wide.

Ports:
- clk  in  1  system clock; the only clock.
- n_rst  in  1  reset, synchronous, active-low; sampled on posedge clk.
- ce  in  1  CPU chip enable.
- rd  in  1  CPU read strobe; may be held for several clk cycles.
- wr  in  1  CPU write strobe; may be held for several clk cycles.
- cd  in  1  CPU register select: 1 = command/status, 0 = data.
- data_in  in  8  CPU write data.
- data_out  out  8  CPU read data, registered; 8'h00 when not being read (not tri-stated).
- rx_irq  out  1  registered; high while the RX FIFO is non-empty.
- sio_ce  out  1  serial block chip enable.
- sio_rd  out  1  serial block read strobe.
- sio_wr  out  1  serial block write strobe.
- sio_cd  out  1  serial block register select.
- sio_data_in  out  8  byte written to the serial block.
- sio_data_out  in  8  serial block read data. Registered on its side, valid the cycle after its read strobe, high-Z otherwise. Status bit1 = rx_ready, bit0 = tx_ready.

## Operation
- CPU access edge detect: an access acts once, in the first cycle that ce&&rd or ce&&wr is seen after it was low. Held strobes cause no repeat. rd has priority if rd and wr are both high.
- Status read (cd=1): data_out <= {5'b0, tx_idle, rx_avail, tx_space}.
  - tx_space = TX FIFO not full.
  - rx_avail = RX FIFO not empty.
  - tx_idle = TX FIFO empty, last polled tx_ready = 1, and the sequencer is not in TX_WRITE.
- Data read (cd=0): data_out <= RX head, and the RX FIFO pops. If the RX FIFO is empty, data_out <= 8'h00 and no pop occurs.
- Command write (cd=1): data_in[0]=1 flushes both FIFOs (pointers and counts go to 0). Other bits are ignored.
- Data write (cd=0): pushes data_in into the TX FIFO. If the FIFO is full, the byte is silently dropped.
- data_out holds its value until the access ends, then returns to 8'h00 the next cycle.
- Sequencer states. In every state, the sio_* strobes not listed are 0.
  - POLL_ISSUE: sio_ce=1, sio_rd=1, sio_cd=1. Next state: POLL_WAIT.
  - POLL_WAIT: latch rx_rdy = sio_data_out[1] and tx_rdy = sio_data_out[0]. Next state, in priority order:
    - RX_ISSUE if rx_rdy and RX FIFO not full;
    - else TX_WRITE if tx_rdy and TX FIFO not empty;
    - else POLL_ISSUE.
  - RX_ISSUE: sio_ce=1, sio_rd=1, sio_cd=0. Next state: RX_WAIT.
  - RX_WAIT: push sio_data_out into the RX FIFO. Next state: TX_WRITE if the latched tx_rdy is set and the TX FIFO is not empty, else POLL_ISSUE. The latched tx_rdy stays valid here because only this block writes the transmitter.
  - TX_WRITE: sio_ce=1, sio_wr=1, sio_cd=0, sio_data_in = TX head; the TX FIFO pops. Next state: POLL_ISSUE.
- If the RX FIFO is full, the sequencer leaves the byte in the serial block. Further incoming bytes are lost there; no overrun flag is kept.
- Simultaneous events:
  - CPU push and sequencer pop on the TX FIFO in the same cycle: both take effect and the count is unchanged.
  - CPU pop and sequencer push on the RX FIFO in the same cycle: both take effect and the count is unchanged.
  - Flush in the same cycle as any push or pop: flush wins. A byte captured in RX_WAIT in that cycle is discarded.
- A flush does not abort the sequencer. The current serial transaction completes, and a TX_WRITE already in progress still sends its byte.

## Timing
- Reset values:
  - data_out = 8'h00, rx_irq = 0.
  - sio_ce = sio_rd = sio_wr = sio_cd = 0, sio_data_in = 8'h00.
  - Both FIFOs empty; state = POLL_ISSUE; rx_rdy = 0, tx_rdy = 1.
- Reset asserted mid-transaction returns everything to these values on the next edge.
- Idle poll loop: 2 cycles.
- RX path: serial rx_ready seen in POLL_WAIT → byte in the FIFO at the end of RX_WAIT, 2 cycles later. rx_irq and status rx_avail rise 1 cycle after that.
- TX path: a byte pushed at edge N is presented to the serial block at most 5 cycles later, assuming its tx_ready = 1.
- CPU read: data_out is valid the cycle after the first strobe cycle.

## Test plan
- Reset, then a CPU status read → data_out = 8'h05 (tx_idle=1, tx_space=1); rx_irq = 0; sio strobes cycle POLL_ISSUE/POLL_WAIT.
- Serial model presents rx_ready with byte 8'hA5 → one data read strobe to the serial block; rx_irq rises; CPU data read returns 8'hA5; rx_irq falls the cycle after the pop.
- CPU writes 8'h3C, 8'h7E while the serial tx_ready=1 → sio_wr pulses carrying 8'h3C, then 8'h7E (each after a new poll shows tx_ready=1); status tx_idle returns to 1 once both are sent.
- Push 17 bytes with tx_ready held 0 → status tx_space = 0 after 16 pushes; the 17th byte is dropped; releasing tx_ready sends exactly 16 bytes in order.
- CPU holds rd for 4 cycles on data, with the RX FIFO containing 8'h11, 8'h22 → exactly one pop; data_out = 8'h11 throughout the access, then 8'h00.
- Flush written in the same cycle as RX_WAIT captures 8'h55 → both FIFOs are empty and rx_irq = 0; a subsequent data read returns 8'h00.
